rho_inv_lane_stream: RTL

// - Lane-serial inverse Keccak rho step for the Kyber Keccak-f[1600] datapath: each 64-bit lane rotated back by its rho offset.
// - Accepts one lane per beat over valid/ready in state order, lane index i = 5*y + x, i = 0..24.
// - Outputs the un-rotated lane stream in the same order, with a 2-entry skid buffer.
// - Used by the permutation-inverse debug/verification path and by serial lane consumers downstream of rho.

---
 rtl/rho_inv_lane_stream_if.sv | 35 +++
 rtl/rho_inv_lane_stream.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rho_inv_lane_stream_if.sv
// rtl/rho_inv_lane_stream_if.sv - lane stream handshake bundle for rho_inv_lane_stream
// Optional macro RHO_INV_FWD_SEL_EN adds the fwd mode-select signal.
interface rho_inv_lane_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_lane;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_lane;
  logic [4:0]  out_idx;
  logic        out_last;
`ifdef RHO_INV_FWD_SEL_EN
  logic        fwd;

  modport master (
    output in_valid, in_lane, out_ready, fwd,
    input  in_ready, out_valid, out_lane, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_lane, out_ready, fwd,
    output in_ready, out_valid, out_lane, out_idx, out_last
  );
`else
  modport master (
    output in_valid, in_lane, out_ready,
    input  in_ready, out_valid, out_lane, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_lane, out_ready,
    output in_ready, out_valid, out_lane, out_idx, out_last
  );
`endif
endinterface

// File: rtl/rho_inv_lane_stream.sv
// rtl/rho_inv_lane_stream.sv - lane-serial inverse Keccak rho with 2-entry skid buffer
// Optional macro RHO_INV_FWD_SEL_EN adds a per-state forward/inverse mode select.
module rho_inv_lane_stream #(
  parameter int LANE_W    = 64,
  parameter int NUM_LANES = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  busy,
  rho_inv_lane_stream_if.slave  lanes
);

  if (LANE_W != 64) begin : g_bad_lane_w
    $fatal(1, "rho_inv_lane_stream: LANE_W must be 64");
  end
  if (NUM_LANES != 25) begin : g_bad_num_lanes
    $fatal(1, "rho_inv_lane_stream: NUM_LANES must be 25");
  end

  // Rho rotation offset for lane i = 5*y + x.
  function automatic logic [5:0] rho_off(input logic [4:0] i);
    logic [5:0] r;
    case (i)
      5'd0:  r = 6'd0;
      5'd1:  r = 6'd1;
      5'd2:  r = 6'd62;
      5'd3:  r = 6'd28;
      5'd4:  r = 6'd27;
      5'd5:  r = 6'd36;
      5'd6:  r = 6'd44;
      5'd7:  r = 6'd6;
      5'd8:  r = 6'd55;
      5'd9:  r = 6'd20;
      5'd10: r = 6'd3;
      5'd11: r = 6'd10;
      5'd12: r = 6'd43;
      5'd13: r = 6'd25;
      5'd14: r = 6'd39;
      5'd15: r = 6'd41;
      5'd16: r = 6'd45;
      5'd17: r = 6'd15;
      5'd18: r = 6'd21;
      5'd19: r = 6'd8;
      5'd20: r = 6'd18;
      5'd21: r = 6'd2;
      5'd22: r = 6'd61;
      5'd23: r = 6'd56;
      5'd24: r = 6'd14;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  logic [4:0]   in_cnt;
  logic [1:0]   count;
  logic [63:0]  slot1_lane;
  logic [4:0]   slot1_idx;
  logic         slot1_last;
  logic         push;
  logic         pop;
  logic [5:0]   r_off;
  logic [127:0] dbl;
  logic [127:0] shr;
  logic [63:0]  rot_lane;
`ifdef RHO_INV_FWD_SEL_EN
  logic         fwd_q;
  logic         fwd_mode;
  logic [127:0] shl;
`endif

  assign push = lanes.in_valid & lanes.in_ready;
  assign pop  = lanes.out_valid & lanes.out_ready;
  assign busy = (in_cnt != 5'd0) || (count != 2'd0);

  // Rotate the incoming lane by its offset; doubling the lane turns the
  // rotation into a plain shift of a 128-bit word.
  always_comb begin
    r_off    = rho_off(in_cnt);
    dbl      = {lanes.in_lane, lanes.in_lane};
    shr      = dbl >> r_off;
`ifdef RHO_INV_FWD_SEL_EN
    shl      = dbl << r_off;
    // Lane 0 carries the mode for the state, so use the live value there.
    fwd_mode = (in_cnt == 5'd0) ? lanes.fwd : fwd_q;
    rot_lane = fwd_mode ? shl[127:64] : shr[63:0];
`else
    rot_lane = shr[63:0];
`endif
  end

  // Lane counter and 2-entry buffer; the head entry drives out_* directly so
  // outputs only change on a pop or on a push into an empty buffer.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      in_cnt          <= 5'd0;
      count           <= 2'd0;
      slot1_lane      <= 64'd0;
      slot1_idx       <= 5'd0;
      slot1_last      <= 1'b0;
      lanes.in_ready  <= 1'b1;
      lanes.out_valid <= 1'b0;
      lanes.out_lane  <= 64'd0;
      lanes.out_idx   <= 5'd0;
      lanes.out_last  <= 1'b0;
`ifdef RHO_INV_FWD_SEL_EN
      fwd_q           <= 1'b0;
`endif
    end else begin
      if (push) begin
        in_cnt <= (in_cnt == 5'd24) ? 5'd0 : in_cnt + 5'd1;
      end
`ifdef RHO_INV_FWD_SEL_EN
      if (push && in_cnt == 5'd0) begin
        fwd_q <= lanes.fwd;
      end
`endif
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            lanes.out_lane <= rot_lane;
            lanes.out_idx  <= in_cnt;
            lanes.out_last <= (in_cnt == 5'd24);
          end else begin
            slot1_lane <= rot_lane;
            slot1_idx  <= in_cnt;
            slot1_last <= (in_cnt == 5'd24);
          end
          count           <= count + 2'd1;
          lanes.out_valid <= 1'b1;
          lanes.in_ready  <= (count == 2'd0);
        end
        2'b01: begin
          if (count == 2'd2) begin
            lanes.out_lane <= slot1_lane;
            lanes.out_idx  <= slot1_idx;
            lanes.out_last <= slot1_last;
          end
          count           <= count - 2'd1;
          lanes.out_valid <= (count == 2'd2);
          lanes.in_ready  <= 1'b1;
        end
        2'b11: begin
          // Only reachable with one entry: the new lane replaces the head.
          lanes.out_lane <= rot_lane;
          lanes.out_idx  <= in_cnt;
          lanes.out_last <= (in_cnt == 5'd24);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
